// File: rtl/dot_fifo_pkg.sv
// Shared types and helpers for the dot-product result FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot_fifo_pkg;

    localparam int DOT_DATA_W = 18;

    typedef logic [DOT_DATA_W-1:0] dot_result_t;

    // Increment a pointer of ptr_w bits, wrapping back to zero past its top value.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/dot_fifo_mem.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the writing clock edge; read is combinational.
// Backpressure: none; the caller decides when to write.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module dot_fifo_mem #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    // Contents are deliberately not reset; the read side masks empty entries.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dot_result_fifo.sv
// FWFT FIFO buffering dot-product results from a producer that cannot be stalled.
// Latency: a result pushed at edge N is presented on out_data/out_valid right after edge N.
// Backpressure: consumer stalls via out_ready; when full with no pop, incoming results are dropped and flagged.
// Ports: clk, reset (async, active-high); in_valid/in_data (producer run/dout);
//        out_valid/out_ready/out_data (FWFT head); count, full, almost_full; overflow (sticky), ovf_clr.
// Option: DOT_RESULT_FIFO_DROP_CNT_EN adds drop_count[7:0], a saturating count of dropped results.
module dot_result_fifo
    import dot_fifo_pkg::*;
#(
    parameter int DATA_W      = DOT_DATA_W,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       ovf_clr
`ifdef DOT_RESULT_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]                 drop_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] mem_rdata;

    assign empty = (wr_ptr_q == rd_ptr_q);

    always_comb begin
        pop  = ~empty & out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push = in_valid & ~(full_q & ~pop);
        drop = in_valid & full_q & ~pop;

        wr_ptr_d = push ? PW'(ptr_inc(32'(wr_ptr_q), PW)) : wr_ptr_q;
        rd_ptr_d = pop  ? PW'(ptr_inc(32'(rd_ptr_q), PW)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase

        // Flags come from the next-state pointers/count so they stay aligned with them.
        full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        afull_d = (count_d >= PW'(AFULL_LEVEL));

        // Clear wins over a coincident drop.
        ovf_d = ovf_clr ? 1'b0 : (drop ? 1'b1 : ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    dot_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign out_valid   = ~empty;
    // Unwritten storage is never exposed: the head reads as zero while empty.
    assign out_data    = empty ? '0 : mem_rdata;
    assign count       = count_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;

`ifdef DOT_RESULT_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        if (ovf_clr) begin
            drop_cnt_d = 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dot_result_fifo.sv
module tb_dot_result_fifo;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [17:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [3:0]  count;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic        ovf_clr;
`ifdef DOT_RESULT_FIFO_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    dot_result_fifo #(
        .DATA_W      (18),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
`ifdef DOT_RESULT_FIFO_DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: inputs are set before the call, outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue plus sticky flag and drop counter.
    int mq[$];
    bit m_ovf;
    int m_dc;

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_dc  = 0;
    endtask

    task automatic model_step(input bit iv, input int id, input bit rdy, input bit clr);
        bit p, d;
        p = (mq.size() > 0) && rdy;
        d = iv && (mq.size() == DEPTH) && !p;
        if (p) void'(mq.pop_front());
        if (iv && !d) mq.push_back(id);
        if (clr)    m_ovf = 1'b0;
        else if (d) m_ovf = 1'b1;
        if (clr)                 m_dc = 0;
        else if (d && m_dc < 255) m_dc = m_dc + 1;
    endtask

    task automatic check_model(input int cycle);
        int exp_dat;
        exp_dat = (mq.size() > 0) ? mq[0] : 0;
        chk($sformatf("rnd%0d_count", cycle), 32'(count), 32'(mq.size()));
        chk($sformatf("rnd%0d_valid", cycle), 32'(out_valid), 32'(mq.size() > 0));
        chk($sformatf("rnd%0d_data", cycle), 32'(out_data), 32'(exp_dat));
        chk($sformatf("rnd%0d_full", cycle), 32'(full), 32'(mq.size() == DEPTH));
        chk($sformatf("rnd%0d_afull", cycle), 32'(almost_full), 32'(mq.size() >= AFULL));
        chk($sformatf("rnd%0d_ovf", cycle), 32'(overflow), 32'(m_ovf));
`ifdef DOT_RESULT_FIFO_DROP_CNT_EN
        chk($sformatf("rnd%0d_dcnt", cycle), 32'(drop_count), 32'(m_dc));
`endif
    endtask

    typedef struct {
        logic        iv;
        logic [17:0] id;
        logic        rdy;
        logic        clr;
        int          ecount;
        logic        evld;
        logic [17:0] edat;
        logic        efull;
        logic        eafull;
        logic        eovf;
    } vec_t;

    vec_t vecs[19];

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        reset     = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int heads[8];
        logic [17:0] d;
        bit iv, rdy, clr;

        // Expected vectors: fill 1..8, overflow, clear, full push+pop, drain.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 18'(i + 1), 1'b0, 1'b0, i + 1, 1'b1, 18'd1,
                        (i == 7), (i + 1 >= AFULL), 1'b0};
        end
        vecs[8]  = '{1'b1, 18'h3FFFF, 1'b0, 1'b0, 8, 1'b1, 18'd1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 18'h0,     1'b0, 1'b1, 8, 1'b1, 18'd1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 18'h12345, 1'b1, 1'b0, 8, 1'b1, 18'd2, 1'b1, 1'b1, 1'b0};
        heads = '{2, 3, 4, 5, 6, 7, 8, 'h12345};
        for (int k = 1; k < 8; k++) begin
            vecs[10 + k] = '{1'b0, 18'h0, 1'b1, 1'b0, 8 - k, 1'b1, 18'(heads[k]),
                             1'b0, (8 - k >= AFULL), 1'b0};
        end
        vecs[18] = '{1'b0, 18'h0, 1'b1, 1'b0, 0, 1'b0, 18'h0, 1'b0, 1'b0, 1'b0};

        // Reset state, sampled while reset is held.
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        reset = 1'b1;
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        do_reset();

        // Table-driven fill/overflow/full-pass-through/drain.
        for (int i = 0; i < 19; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].rdy;
            ovf_clr   = vecs[i].clr;
            cyc();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecount));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].evld));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].edat));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].efull));
            chk($sformatf("vec%0d_afull", i), 32'(almost_full), 32'(vecs[i].eafull));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eovf));
        end
        ovf_clr = 1'b0;

        // Producer cadence: one result every 6 cycles, consumer always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d = 18'($urandom);
            in_valid = 1'b1;
            in_data  = d;
            cyc();
            chk("cad_valid", 32'(out_valid), 1);
            chk("cad_data", 32'(out_data), 32'(d));
            chk("cad_count1", 32'(count), 1);
            in_valid = 1'b0;
            cyc();
            chk("cad_count0", 32'(count), 0);
            chk("cad_afull", 32'(almost_full), 0);
            repeat (4) cyc();
        end

        // Reset mid-operation, asserted between clock edges.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(k + 100);
            cyc();
        end
        in_valid = 1'b0;
        chk("mid_pre_count", 32'(count), 5);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_count", 32'(count), 0);
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_data", 32'(out_data), 0);
        in_valid = 1'b1;
        in_data  = '0;
        cyc();
        reset = 1'b0;
        cyc();
        in_valid = 1'b0;
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_data", 32'(out_data), 0);
        out_ready = 1'b1;
        cyc();
        chk("post_rst_drain", 32'(count), 0);

`ifdef DOT_RESULT_FIFO_DROP_CNT_EN
        // Drop counter saturation and clear.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1;
            in_data  = 18'(k);
            cyc();
        end
        repeat (300) cyc();
        chk("dcnt_sat", 32'(drop_count), 255);
        chk("dcnt_ovf", 32'(overflow), 1);
        chk("dcnt_count", 32'(count), 8);
        ovf_clr = 1'b1;
        cyc();
        chk("dcnt_clr", 32'(drop_count), 0);
        chk("dcnt_clr_ovf", 32'(overflow), 0);
        ovf_clr = 1'b0;
        cyc();
        chk("dcnt_one", 32'(drop_count), 1);
        in_valid = 1'b0;
`endif

        // Randomized traffic against the queue model, with phases biased to fill and to drain.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            iv  = ($urandom_range(99) < ((c / 200) % 2 == 0 ? 80 : 40));
            rdy = ($urandom_range(99) < ((c / 200) % 2 == 0 ? 30 : 75));
            clr = ($urandom_range(99) < 4);
            d   = 18'($urandom);
            in_valid  = iv;
            in_data   = d;
            out_ready = rdy;
            ovf_clr   = clr;
            model_step(iv, int'(d), rdy, clr);
            cyc();
            check_model(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
